// File: rtl/instruction_buffer.sv
// Circular instruction FIFO between Fetch and Dispatch; up to `N in and `N out per cycle.
// Optional same-cycle fetch-to-dispatch bypass is enabled by defining IB_BYPASS_EN.

`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

package instruction_buffer_pkg;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ib_packet_t;
endpackage

module instruction_buffer
    import instruction_buffer_pkg::*;
#(
    parameter int unsigned IB_DEPTH = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  ib_packet_t [`N-1:0]               fetch_packets,
    input  logic [`NUM_SCALAR_BITS-1:0]       num_fetched,
    output logic [`NUM_SCALAR_BITS-1:0]       ib_spots,
    output ib_packet_t [`N-1:0]               instruction_packets,
    output logic [`NUM_SCALAR_BITS-1:0]       instructions_valid,
    input  logic [`NUM_SCALAR_BITS-1:0]       num_dispatched,
    input  logic                              flush
);

    localparam int unsigned N     = `N;
    localparam int unsigned SW    = `NUM_SCALAR_BITS;
    localparam int unsigned IDX_W = $clog2(N);
    localparam int unsigned PTR_W = $clog2(IB_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    ib_packet_t       mem_q [IB_DEPTH];
    ib_packet_t       mem_d [IB_DEPTH];

    logic [CNT_W-1:0] free_c;
    logic [CNT_W-1:0] buf_shown_c;
    logic [CNT_W-1:0] spots_c;
    logic [CNT_W-1:0] enq_c;
    logic [CNT_W-1:0] out_valid_c;
    logic [CNT_W-1:0] deq_c;
    logic [CNT_W-1:0] deq_buf_c;
    logic [CNT_W-1:0] byp_used_c;

    function automatic logic [CNT_W-1:0] cmin(input logic [CNT_W-1:0] a,
                                              input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Occupancy-derived handshake counts; free space ignores same-cycle pops.
    always_comb begin
        free_c      = CNT_W'(IB_DEPTH) - count_q;
        buf_shown_c = cmin(count_q, CNT_W'(N));
        spots_c     = cmin(free_c, CNT_W'(N));
        enq_c       = (reset || flush) ? '0 : cmin(CNT_W'(num_fetched), spots_c);
`ifdef IB_BYPASS_EN
        out_valid_c = cmin(count_q + enq_c, CNT_W'(N));
`else
        out_valid_c = buf_shown_c;
`endif
        deq_c       = cmin(CNT_W'(num_dispatched), out_valid_c);
        // Pops beyond the buffered entries are fetch entries dispatched straight through.
        deq_buf_c   = cmin(deq_c, buf_shown_c);
        byp_used_c  = deq_c - deq_buf_c;
    end

    // Pointer and occupancy update; flush empties the buffer.
    always_comb begin
        head_d  = head_q + PTR_W'(deq_buf_c);
        tail_d  = tail_q + PTR_W'(enq_c - byp_used_c);
        count_d = count_q + enq_c - deq_c;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Write only the accepted fetch entries that were not bypassed to Dispatch.
    always_comb begin
        mem_d = mem_q;
        for (int unsigned i = 0; i < N; i++) begin
            if ((CNT_W'(i) >= byp_used_c) && (CNT_W'(i) < enq_c)) begin
                mem_d[tail_q + PTR_W'(i) - PTR_W'(byp_used_c)] = fetch_packets[IDX_W'(i)];
            end
        end
    end

    // Dispatch window: oldest buffered entries first, then bypassed fetch entries.
    always_comb begin
        instruction_packets = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (CNT_W'(i) < buf_shown_c) begin
                instruction_packets[IDX_W'(i)] = mem_q[head_q + PTR_W'(i)];
            end
`ifdef IB_BYPASS_EN
            else if (CNT_W'(i) < out_valid_c) begin
                instruction_packets[IDX_W'(i)] = fetch_packets[IDX_W'(CNT_W'(i) - buf_shown_c)];
            end
`endif
        end
        instructions_valid = SW'(out_valid_c);
        ib_spots           = SW'(spots_c);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage carries no reset; validity is tracked by count_q alone.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_instruction_buffer.sv
// Self-checking bench for instruction_buffer: directed scenarios plus randomized traffic
// against a queue-based reference model.

`ifndef N
`define N 3
`endif
`ifndef NUM_SCALAR_BITS
`define NUM_SCALAR_BITS 2
`endif

module tb_instruction_buffer;
    import instruction_buffer_pkg::*;

    localparam int N     = `N;
    localparam int SW    = `NUM_SCALAR_BITS;
    localparam int IDX_W = $clog2(N);
    localparam int DEPTH = 16;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  flush;
    ib_packet_t [N-1:0]    fetch_packets;
    ib_packet_t [N-1:0]    instruction_packets;
    logic [SW-1:0]         num_fetched;
    logic [SW-1:0]         num_dispatched;
    logic [SW-1:0]         ib_spots;
    logic [SW-1:0]         instructions_valid;

    int          checks = 0;
    int          errors = 0;
    ib_packet_t  mq[$];
    ib_packet_t  fq[$];
    logic [31:0] next_pc = 32'h0;

    instruction_buffer #(.IB_DEPTH(DEPTH)) dut (
        .clock              (clock),
        .reset              (reset),
        .fetch_packets      (fetch_packets),
        .num_fetched        (num_fetched),
        .ib_spots           (ib_spots),
        .instruction_packets(instruction_packets),
        .instructions_valid (instructions_valid),
        .num_dispatched     (num_dispatched),
        .flush              (flush)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Reference model: buffer contents as a queue, oldest first.
    function automatic int imin(int a, int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int m_spots();
        return imin(DEPTH - mq.size(), N);
    endfunction

    function automatic int m_enq();
        if (reset || flush) return 0;
        return imin(int'(num_fetched), m_spots());
    endfunction

    function automatic int m_valid();
`ifdef IB_BYPASS_EN
        return imin(mq.size() + m_enq(), N);
`else
        return imin(mq.size(), N);
`endif
    endfunction

    function automatic ib_packet_t m_pkt(int i);
        if (i >= m_valid()) return '0;
        if (i < mq.size()) return mq[i];
        return fq[i - mq.size()];
    endfunction

    task automatic drive(int nf, int nd, bit fl, bit rs);
        ib_packet_t p;
        fq.delete();
        for (int i = 0; i < N; i++) begin
            p.inst = $urandom;
            p.pc   = next_pc + 32'(4 * i);
            fetch_packets[IDX_W'(i)] = p;
            fq.push_back(p);
        end
        num_fetched    = SW'(nf);
        num_dispatched = SW'(nd);
        flush          = fl;
        reset          = rs;
        #1;
    endtask

    task automatic advance();
        int enq;
        int deq;
        enq = m_enq();
        deq = imin(int'(num_dispatched), m_valid());
        if (reset || flush) begin
            mq.delete();
        end else begin
            for (int j = 0; j < enq; j++) mq.push_back(fq[j]);
            repeat (deq) void'(mq.pop_front());
        end
        next_pc = next_pc + 32'(4 * enq);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 1'b0, 1'b1);
        advance();
        drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        drive(3, 3, 1'b1, 1'b1);
        advance();
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (instructions_valid !== SW'(0)) begin
            errors++;
            $display("FAIL reset_valid: got %0d want 0", instructions_valid);
        end
        checks++;
        if (ib_spots !== SW'(N)) begin
            errors++;
            $display("FAIL reset_spots: got %0d want %0d", ib_spots, N);
        end
        checks++;
        if (instruction_packets !== '0) begin
            errors++;
            $display("FAIL reset_packets: got %h want 0", instruction_packets);
        end
    endtask

    task automatic test_first_fetch();
        do_reset();
        next_pc = 32'h0;
        drive(3, 0, 1'b0, 1'b0);
        advance();
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (instructions_valid !== SW'(3)) begin
            errors++;
            $display("FAIL first_valid: got %0d want 3", instructions_valid);
        end
        checks++;
        if (ib_spots !== SW'(3)) begin
            errors++;
            $display("FAIL first_spots: got %0d want 3", ib_spots);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (instruction_packets[IDX_W'(i)].pc !== 32'(4 * i)) begin
                errors++;
                $display("FAIL first_pc[%0d]: got %h want %h", i,
                         instruction_packets[IDX_W'(i)].pc, 32'(4 * i));
            end
        end
    endtask

    task automatic test_full();
        logic [31:0] start_pc;
        int          drained;
        int          remaining;
        int          exp_v;
        do_reset();
        start_pc = next_pc;
        repeat (6) begin
            drive(3, 0, 1'b0, 1'b0);
            advance();
        end
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (ib_spots !== SW'(0)) begin
            errors++;
            $display("FAIL full_spots: got %0d want 0", ib_spots);
        end
        drive(3, 0, 1'b0, 1'b0);
        advance();
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (ib_spots !== SW'(0)) begin
            errors++;
            $display("FAIL full_spots_after_push: got %0d want 0", ib_spots);
        end
        drained   = 0;
        remaining = DEPTH;
        for (int c = 0; c < 7; c++) begin
            drive(0, 3, 1'b0, 1'b0);
            exp_v = imin(remaining, N);
            checks++;
            if (instructions_valid !== SW'(exp_v)) begin
                errors++;
                $display("FAIL full_drain_valid: got %0d want %0d", instructions_valid, exp_v);
            end
            for (int i = 0; i < exp_v; i++) begin
                checks++;
                if (instruction_packets[IDX_W'(i)].pc !== start_pc + 32'(4 * (drained + i))) begin
                    errors++;
                    $display("FAIL full_drain_pc: got %h want %h",
                             instruction_packets[IDX_W'(i)].pc, start_pc + 32'(4 * (drained + i)));
                end
            end
            drained   += exp_v;
            remaining -= exp_v;
            advance();
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] base;
        int          exp_v;
        int          first;
        do_reset();
        drive(2, 0, 1'b0, 1'b0);
        advance();
        base = next_pc;
        drive(3, 3, 1'b0, 1'b0);
        advance();
        drive(0, 0, 1'b0, 1'b0);
`ifdef IB_BYPASS_EN
        exp_v = 2;
        first = 1;
`else
        exp_v = 3;
        first = 0;
`endif
        checks++;
        if (instructions_valid !== SW'(exp_v)) begin
            errors++;
            $display("FAIL simul_valid: got %0d want %0d", instructions_valid, exp_v);
        end
        for (int i = 0; i < exp_v; i++) begin
            checks++;
            if (instruction_packets[IDX_W'(i)].pc !== base + 32'(4 * (first + i))) begin
                errors++;
                $display("FAIL simul_pc[%0d]: got %h want %h", i,
                         instruction_packets[IDX_W'(i)].pc, base + 32'(4 * (first + i)));
            end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] base;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            drive((c < 4) ? 3 : 2, 0, 1'b0, 1'b0);
            advance();
        end
        for (int c = 0; c < 5; c++) begin
            drive(0, (c < 4) ? 3 : 2, 1'b0, 1'b0);
            advance();
        end
        base = next_pc;
        drive(3, 0, 1'b0, 1'b0);
        advance();
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (instructions_valid !== SW'(3)) begin
            errors++;
            $display("FAIL wrap_valid: got %0d want 3", instructions_valid);
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (instruction_packets[IDX_W'(i)] !== m_pkt(i)
                || instruction_packets[IDX_W'(i)].pc !== base + 32'(4 * i)) begin
                errors++;
                $display("FAIL wrap_pkt[%0d]: got %h want pc %h", i,
                         instruction_packets[IDX_W'(i)], base + 32'(4 * i));
            end
        end
        drive(0, 3, 1'b0, 1'b0);
        advance();
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (instructions_valid !== SW'(0) || ib_spots !== SW'(3)) begin
            errors++;
            $display("FAIL wrap_drain: got valid %0d spots %0d want 0 3", instructions_valid, ib_spots);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            drive((c < 3) ? 3 : 1, 0, 1'b0, 1'b0);
            advance();
        end
        drive(3, 0, 1'b1, 1'b0);
        advance();
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (instructions_valid !== SW'(0) || ib_spots !== SW'(3)) begin
            errors++;
            $display("FAIL flush_state: got valid %0d spots %0d want 0 3", instructions_valid, ib_spots);
        end
        drive(3, 0, 1'b0, 1'b0);
        advance();
        drive(3, 2, 1'b1, 1'b1);
        advance();
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (instructions_valid !== SW'(0) || ib_spots !== SW'(3) || instruction_packets !== '0) begin
            errors++;
            $display("FAIL flush_reset: got valid %0d spots %0d want 0 3", instructions_valid, ib_spots);
        end
    endtask

    task automatic test_latency();
        logic [31:0] base;
        do_reset();
        base = next_pc;
        drive(2, 2, 1'b0, 1'b0);
`ifdef IB_BYPASS_EN
        checks++;
        if (instructions_valid !== SW'(2)) begin
            errors++;
            $display("FAIL bypass_valid: got %0d want 2", instructions_valid);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (instruction_packets[IDX_W'(i)].pc !== base + 32'(4 * i)) begin
                errors++;
                $display("FAIL bypass_pc[%0d]: got %h want %h", i,
                         instruction_packets[IDX_W'(i)].pc, base + 32'(4 * i));
            end
        end
        advance();
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (instructions_valid !== SW'(0)) begin
            errors++;
            $display("FAIL bypass_next_valid: got %0d want 0", instructions_valid);
        end
`else
        checks++;
        if (instructions_valid !== SW'(0)) begin
            errors++;
            $display("FAIL latency_same_cycle: got %0d want 0", instructions_valid);
        end
        advance();
        drive(0, 0, 1'b0, 1'b0);
        checks++;
        if (instructions_valid !== SW'(2) || instruction_packets[IDX_W'(1)].pc !== base + 32'h4) begin
            errors++;
            $display("FAIL latency_next_cycle: got %0d want 2", instructions_valid);
        end
`endif
    endtask

    task automatic test_random();
        int nf;
        int nd;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            nf = $urandom_range(0, 3);
            nd = ((c / 100) % 2 == 0) ? $urandom_range(0, 1) : $urandom_range(0, 3);
            drive(nf, nd, ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
            checks++;
            if (instructions_valid !== SW'(m_valid())) begin
                errors++;
                $display("FAIL rand_valid cyc %0d: got %0d want %0d", c, instructions_valid, m_valid());
            end
            checks++;
            if (ib_spots !== SW'(m_spots())) begin
                errors++;
                $display("FAIL rand_spots cyc %0d: got %0d want %0d", c, ib_spots, m_spots());
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (instruction_packets[IDX_W'(i)] !== m_pkt(i)) begin
                    errors++;
                    $display("FAIL rand_pkt[%0d] cyc %0d: got %h want %h", i, c,
                             instruction_packets[IDX_W'(i)], m_pkt(i));
                end
            end
            advance();
        end
    endtask

    initial begin
        drive(0, 0, 1'b0, 1'b1);
        advance();
        advance();
        test_reset();
        test_first_fetch();
        test_full();
        test_simultaneous();
        test_wrap();
        test_flush();
        test_latency();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instruction_buffer.md
INSTRUCTION_BUFFER -- requirements
Module: instruction_buffer

Interface
REQ-001 SHALL have parameter IB_DEPTH, default 16, number of entries; power of two, >= 2*`N.
REQ-002 SHALL have port clock, input, 1, rising-edge clock.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port fetch_packets, input, `N x {inst 32b, PC 32b}, fetched instructions; slot 0 is oldest.
REQ-005 SHALL have port num_fetched, input, `NUM_SCALAR_BITS, count of valid fetch_packets (slots 0..num_fetched-1).
REQ-006 SHALL have port ib_spots, output, `NUM_SCALAR_BITS, free entries saturated at `N.
REQ-007 SHALL have port instruction_packets, output, `N x {inst, PC}, oldest buffered instructions to Dispatch.
REQ-008 SHALL have port instructions_valid, output, `NUM_SCALAR_BITS, count of valid instruction_packets.
REQ-009 SHALL have port num_dispatched, input, `NUM_SCALAR_BITS, entries consumed by Dispatch this cycle.
REQ-010 SHALL have port flush, input, 1, branch-stack restore; discards all contents.

Function
REQ-011 SHALL be a circular FIFO with head, tail and count registers; pointers wrap modulo IB_DEPTH.
REQ-012 SHALL drive instruction_packets[i] = entry[(head+i) mod IB_DEPTH] for i < instructions_valid, zero otherwise.
REQ-013 SHALL drive instructions_valid = min(count, `N) and ib_spots = min(IB_DEPTH-count, `N), both from registered state only.
REQ-014 SHALL accept enq = min(num_fetched, ib_spots) entries per cycle; excess entries silently dropped.
REQ-015 SHALL pop deq = min(num_dispatched, instructions_valid) entries per cycle; excess requests ignored.
REQ-016 SHALL apply simultaneous enqueue and dequeue in one cycle: next count = count + enq - deq; free space for enqueue excludes same-cycle pops.
REQ-017 SHALL make newly enqueued entries visible on outputs the cycle after acceptance (1-cycle latency) without IB_BYPASS_EN.
REQ-018 SHALL give flush priority over enqueue and dequeue: next cycle head = tail = count = 0; same-cycle fetch_packets discarded.
REQ-019 SHALL preserve program order across pointer wrap-around, including an `N-wide write or read spanning the IB_DEPTH-1 -> 0 boundary.
REQ-020 SHALL when full (count = IB_DEPTH) drive ib_spots = 0 and accept nothing; when empty drive instructions_valid = 0.

Reset
REQ-021 SHALL on reset set head = tail = count = 0; next cycle instructions_valid = 0, ib_spots = `N, instruction_packets all zero.
REQ-022 SHALL give reset priority over flush, enqueue and dequeue; reset mid-stream discards all contents.
REQ-023 SHALL not require reset of entry storage.

Configuration
REQ-024 SHALL support macro IB_BYPASS_EN; when undefined, behaviour is exactly REQ-011..REQ-020.
REQ-025 SHALL when IB_BYPASS_EN defined, present buffered entries followed by same-cycle accepted fetch entries on instruction_packets, instructions_valid = min(count+enq, `N).
REQ-026 SHALL when IB_BYPASS_EN defined, never write to storage fetch entries consumed by same-cycle dispatch; flush still suppresses bypass output.

Verification (N=3, IB_DEPTH=16)
REQ-027 SHALL cover: reset, then num_fetched=3 PCs 0x0/0x4/0x8 -> next cycle instructions_valid=3, packets PC 0x0,0x4,0x8, ib_spots=3.
REQ-028 SHALL cover: fill to count=16 -> ib_spots=0; num_fetched=3 with num_dispatched=0 -> count stays 16, no entry overwritten.
REQ-029 SHALL cover: count=2, num_fetched=3, num_dispatched=3 -> deq=2, enq=3, next count=3, outputs the three new PCs in order.
REQ-030 SHALL cover: head=14, count=3 -> packets from entries 14,15,0 in order; dispatch 3 -> head=1, count=0.
REQ-031 SHALL cover: count=10, flush=1 with num_fetched=3 -> next cycle instructions_valid=0, ib_spots=3; flush with reset -> reset state.
REQ-032 SHALL cover with IB_BYPASS_EN: empty buffer, num_fetched=2, num_dispatched=2 -> same-cycle instructions_valid=2, next count=0.
